// File: rtl/jk_pattern_driver.sv
// Converts a WIDTH-bit target pattern into per-cycle J/K commands for a negedge JK
// flip-flop, checks the fed-back Q against each previously driven target bit.
module jk_pattern_driver #(
  parameter int WIDTH   = 8,
  parameter int DC_MODE = 0,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int   IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic DC    = (DC_MODE != 0);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [WIDTH-1:0] r_pat, w_pat_nxt;
  logic             r_exp, w_exp_nxt;
  logic             r_j, w_j_nxt, r_k, w_k_nxt;
  logic             r_done, w_done_nxt, r_mm, w_mm_nxt;
  logic [ERR_W-1:0] r_err, w_err_nxt;

  logic w_tgt, w_j, w_k, w_bad, w_last;
  logic [ERR_W-1:0] w_err_inc;

  // Excitation is computed from the observed Q, so a missed transition self-corrects.
  assign w_tgt     = (r_state == IDLE) ? load_data[0] : r_pat[0];
  assign w_j       = q_fb ? DC : w_tgt;
  assign w_k       = q_fb ? ~w_tgt : DC;
  assign w_bad     = (q_fb != r_exp);
  assign w_last    = (r_idx == IDX_W'(WIDTH-1));
  assign w_err_inc = (&r_err) ? r_err : r_err + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pat_nxt   = r_pat;
    w_exp_nxt   = r_exp;
    w_j_nxt     = 1'b0;
    w_k_nxt     = 1'b0;
    w_done_nxt  = 1'b0;
    w_mm_nxt    = 1'b0;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE: begin
        if (load_valid) begin
          w_state_nxt = RUN;
          w_idx_nxt   = '0;
          w_pat_nxt   = load_data >> 1;
          w_exp_nxt   = load_data[0];
          w_j_nxt     = w_j;
          w_k_nxt     = w_k;
          w_err_nxt   = '0;
        end
      end
      RUN: begin
        w_mm_nxt = w_bad;
        if (w_bad) w_err_nxt = w_err_inc;
        if (w_last) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
          w_pat_nxt = r_pat >> 1;
          w_exp_nxt = r_pat[0];
          w_j_nxt   = w_j;
          w_k_nxt   = w_k;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_pat   <= '0;
      r_exp   <= 1'b0;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_done  <= 1'b0;
      r_mm    <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_pat   <= w_pat_nxt;
      r_exp   <= w_exp_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
      r_done  <= w_done_nxt;
      r_mm    <= w_mm_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign load_ready = (r_state == IDLE);
  assign busy       = (r_state == RUN);
  assign j          = r_j;
  assign k          = r_k;
  assign done       = r_done;
  assign mismatch   = r_mm;
  assign err_cnt    = r_err;

endmodule

// File: tb/tb_jk_pattern_driver.sv
// Directed bench: two drivers (DC_MODE 0 and 1), each closing the loop through a
// behavioural negedge JK flip-flop; expected J/K sequences are hand-derived.
module tb_jk_pattern_driver;
  logic clk = 1'b0;
  logic rst;
  logic lv0, ready0, j0, k0, busy0, done0, mm0;
  logic [7:0] ld0, err0;
  logic q0 = 1'b0;
  logic stuck = 1'b0;
  logic lv1, ready1, j1, k1, busy1, done1, mm1;
  logic [7:0] ld1, err1;
  logic q1 = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  logic [1:0] jkx [8];
  logic [1:0] jk1 [8];

  always #5 clk = ~clk;

  jk_pattern_driver #(.WIDTH(8), .DC_MODE(0), .ERR_W(8)) dut0 (
    .clk(clk), .rst(rst), .load_valid(lv0), .load_ready(ready0), .load_data(ld0),
    .j(j0), .k(k0), .q_fb(q0), .busy(busy0), .done(done0), .mismatch(mm0), .err_cnt(err0));

  jk_pattern_driver #(.WIDTH(8), .DC_MODE(1), .ERR_W(8)) dut1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(ready1), .load_data(ld1),
    .j(j1), .k(k1), .q_fb(q1), .busy(busy1), .done(done1), .mismatch(mm1), .err_cnt(err1));

  // Negedge JK flip-flop models; dut0's can be forced stuck at 0.
  always @(negedge clk) begin
    if (stuck) q0 <= 1'b0;
    else case ({j0, k0})
      2'b01: q0 <= 1'b0;
      2'b10: q0 <= 1'b1;
      2'b11: q0 <= ~q0;
      default: ;
    endcase
  end

  always @(negedge clk) begin
    case ({j1, k1})
      2'b01: q1 <= 1'b0;
      2'b10: q1 <= 1'b1;
      2'b11: q1 <= ~q1;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full burst on dut0; jkx holds the expected J/K after E0..E7.
  task automatic burst0(input string nm, input logic [7:0] pat, input bit hold,
                        input logic [7:0] mm_exp, input int err_exp);
    ld0 = pat;
    lv0 = 1'b1;
    tick;
    chk({nm, "_acc_busy"}, busy0, 1);
    chk({nm, "_acc_rdy"}, ready0, 0);
    chk({nm, "_jk0"}, {j0, k0}, jkx[0]);
    chk({nm, "_acc_err"}, err0, 0);
    if (!hold) lv0 = 1'b0;
    ld0 = ~pat;
    for (int i = 1; i <= 8; i++) begin
      tick;
      chk($sformatf("%s_mm%0d", nm, i), mm0, mm_exp[i-1]);
      if (i < 8) begin
        chk($sformatf("%s_jk%0d", nm, i), {j0, k0}, jkx[i]);
        chk($sformatf("%s_done%0d", nm, i), done0, 0);
        chk($sformatf("%s_busy%0d", nm, i), busy0, 1);
      end else begin
        chk({nm, "_jk_end"}, {j0, k0}, 0);
        chk({nm, "_done"}, done0, 1);
        chk({nm, "_busy_end"}, busy0, 0);
        chk({nm, "_rdy_end"}, ready0, 1);
        chk({nm, "_err"}, err0, err_exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; lv0 = 1'b1; lv1 = 1'b1; ld0 = 8'h55; ld1 = 8'h55;
    tick;
    tick;
    chk("rst_jk0", {j0, k0}, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_rdy0", ready0, 1);
    chk("rst_done0", done0, 0);
    chk("rst_mm0", mm0, 0);
    chk("rst_err0", err0, 0);
    chk("rst_jk1", {j1, k1}, 0);
    chk("rst_busy1", busy1, 0);
    rst = 1'b0; lv0 = 1'b0; lv1 = 1'b0;
    tick;
    chk("idle_busy0", busy0, 0);

    // DC_MODE=0, Q=0, pattern A6
    jkx = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10};
    burst0("a6", 8'hA6, 1'b0, 8'h00, 0);
    chk("a6_q", q0, 1);
    tick;
    chk("a6_done_drop", done0, 0);

    // DC_MODE=1, Q=0, pattern A6
    jk1 = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11};
    ld1 = 8'hA6; lv1 = 1'b1;
    tick;
    chk("dc1_jk0", {j1, k1}, jk1[0]);
    lv1 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick;
      chk($sformatf("dc1_mm%0d", i), mm1, 0);
      if (i < 8) chk($sformatf("dc1_jk%0d", i), {j1, k1}, jk1[i]);
    end
    chk("dc1_done", done1, 1);
    chk("dc1_err", err1, 0);
    chk("dc1_rdy", ready1, 1);
    chk("dc1_q", q1, 1);

    // Stuck-at-0 flip-flop: every bit of FF mismatches
    stuck = 1'b1;
    tick;
    jkx = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    burst0("stk", 8'hFF, 1'b0, 8'hFF, 8);
    stuck = 1'b0;
    tick;
    chk("stk_err_hold", err0, 8);
    jkx = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    burst0("clr", 8'h00, 1'b0, 8'h00, 0);

    // Back-to-back with load_valid held: second accept lands at E9
    tick;
    jkx = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    burst0("b0f", 8'h0F, 1'b1, 8'h00, 0);
    jkx = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    burst0("bf0", 8'hF0, 1'b1, 8'h00, 0);
    lv0 = 1'b0;
    chk("bf0_q", q0, 1);
    tick;

    // Reset during a burst (pattern 55 from Q=1)
    ld0 = 8'h55; lv0 = 1'b1;
    tick;
    chk("mid_jk0", {j0, k0}, 2'b00);
    lv0 = 1'b0;
    tick;
    chk("mid_jk1", {j0, k0}, 2'b01);
    tick;
    chk("mid_jk2", {j0, k0}, 2'b10);
    tick;
    chk("mid_jk3", {j0, k0}, 2'b01);
    rst = 1'b1;
    tick;
    chk("mid_rst_jk", {j0, k0}, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_done", done0, 0);
    chk("mid_rst_rdy", ready0, 1);
    chk("mid_rst_err", err0, 0);
    rst = 1'b0;
    tick;
    chk("mid_post_done", done0, 0);
    chk("mid_post_busy", busy0, 0);
    jkx = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10};
    burst0("post", 8'hA6, 1'b0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
